// File: rtl/z_core_alu_arb.sv
`default_nettype none
// ============================================================================
// Module   : z_core_alu_arb
// Purpose  : Two-requester arbiter and sequencer for the shared Z-Core ALU.
//            Port 0 is the core execute stage and port 1 is a secondary
//            requester (debug or coprocessor). One requester is granted at a
//            time. Its op and operands are latched, driven to the ALU from
//            registers for one cycle, and the captured result is returned to
//            that requester with a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH  operand / result width (default 32)
//   OP_WIDTH    ALU operation code width (default 4)
// Ports
//   clk                      rising-edge clock
//   rstn                     asynchronous active-low reset
//   r0_valid / r1_valid      request valid per port
//   r0_ready / r1_ready      one-cycle grant pulse (only in IDLE)
//   r0_op / r1_op            operation code per port
//   r0_a, r0_b, r1_a, r1_b   operands per port
//   r0_rsp_valid/r1_rsp_valid  response valid (granted port only)
//   r0_rsp_ready/r1_rsp_ready  response accepted by requester
//   r0_rsp_data/r1_rsp_data    result (0 on the non-granted port)
//   alu_op, alu_a, alu_b     issue registers driven to the shared ALU
//   alu_result               combinational ALU result
// Configuration
//   Z_CORE_ALU_ARB_RR_EN     defined   : round-robin tie break
//                            undefined : fixed priority, port 0 wins ties
// ============================================================================
module z_core_alu_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  // port 0 request
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [OP_WIDTH-1:0]   r0_op,
  input  logic [DATA_WIDTH-1:0] r0_a,
  input  logic [DATA_WIDTH-1:0] r0_b,
  // port 1 request
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [OP_WIDTH-1:0]   r1_op,
  input  logic [DATA_WIDTH-1:0] r1_a,
  input  logic [DATA_WIDTH-1:0] r1_b,
  // port 0 response
  output logic                  r0_rsp_valid,
  input  logic                  r0_rsp_ready,
  output logic [DATA_WIDTH-1:0] r0_rsp_data,
  // port 1 response
  output logic                  r1_rsp_valid,
  input  logic                  r1_rsp_ready,
  output logic [DATA_WIDTH-1:0] r1_rsp_data,
  // shared ALU
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_gnt;     // index of the port currently being served
  logic [OP_WIDTH-1:0]   r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_result;

  logic                  w_any_valid;
  logic                  w_win;     // arbitration winner index
  logic                  w_grant;   // a grant is issued this cycle
  logic                  w_rsp_ack; // granted port accepts the response

  assign w_any_valid = r0_valid | r1_valid;

  // Grants happen only in IDLE. Qualifying with rstn keeps both ready
  // outputs low while reset is asserted even if a requester holds valid,
  // since the state register already reads IDLE during reset.
  assign w_grant = (r_state == ST_IDLE) && rstn && w_any_valid;

  // Only the granted port's rsp_ready matters; the other one is ignored.
  assign w_rsp_ack = r_gnt ? r1_rsp_ready : r0_rsp_ready;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef Z_CORE_ALU_ARB_RR_EN
  // Last-served pointer. It resets to 1 so that port 0 wins the first tie.
  logic r_last;

  // Single requester wins outright; on a tie the port not served last wins.
  assign w_win = (r0_valid && r1_valid) ? ~r_last : r1_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= 1'b1;
    end else if (w_grant) begin
      r_last <= w_win;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it is requesting.
  assign w_win = ~r0_valid;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;
    r0_rsp_data  = '0;
    r1_rsp_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          r0_ready    = ~w_win;
          r1_ready    = w_win;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        // The ack only returns to IDLE; the next grant is evaluated there,
        // so rsp_ready never reaches the ready outputs combinationally.
        if (r_gnt) begin
          r1_rsp_valid = 1'b1;
          r1_rsp_data  = r_result;
        end else begin
          r0_rsp_valid = 1'b1;
          r0_rsp_data  = r_result;
        end
        if (w_rsp_ack) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Issue registers: capture the winner's request on the grant
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_gnt <= 1'b0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_grant) begin
      r_gnt <= w_win;
      if (w_win) begin
        r_op <= r1_op;
        r_a  <= r1_a;
        r_b  <= r1_b;
      end else begin
        r_op <= r0_op;
        r_a  <= r0_a;
        r_b  <= r0_b;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result register: the ALU output is sampled only at the end of EXEC
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_result <= '0;
    end else if (r_state == ST_EXEC) begin
      r_result <= alu_result;
    end
  end

  // The ALU is always driven from the issue registers. Its result is only
  // used in EXEC.
  assign alu_op = r_op;
  assign alu_a  = r_a;
  assign alu_b  = r_b;

endmodule
`default_nettype wire
